// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_kind_t;

  // Key codes indexed by {row, col}; entry 0 (row 0, col 0) is the LSB nibble.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

endpackage

// File: rtl/keypad_col_scan.sv
// Column drive, row synchronizer and per-scan accumulation of pressed keys.
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       scan_done,
  output scan_kind_t scan_kind,
  output logic [3:0] scan_code
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] dwell;
  logic [1:0]    col;
  logic [1:0]    col_next;
  logic [3:0]    rows_meta;
  logic [3:0]    rows_sync;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;

  logic [3:0]    hits;
  logic [2:0]    col_cnt;
  logic [1:0]    hit_row;
  logic [3:0]    col_code;
  logic [1:0]    tot_cnt;
  logic [3:0]    tot_code;

  // Merge this column's sample into the running scan result; count saturates at 2.
  always_comb begin
    hits     = ~rows_sync;
    col_cnt  = 3'(hits[0]) + 3'(hits[1]) + 3'(hits[2]) + 3'(hits[3]);
    hit_row  = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (hits[r]) hit_row = 2'(r);
    end
    col_code = KEY_MAP[{hit_row, col}];
    if (3'(acc_cnt) + col_cnt >= 3'd2) tot_cnt = 2'd2;
    else                               tot_cnt = acc_cnt + 2'(col_cnt);
    tot_code = (acc_cnt != 2'd0) ? acc_code : col_code;
    col_next = col + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell     <= '0;
      col       <= 2'd0;
      cols      <= 4'b1110;
      rows_meta <= 4'hF;
      rows_sync <= 4'hF;
      acc_cnt   <= 2'd0;
      acc_code  <= 4'h0;
      scan_done <= 1'b0;
      scan_kind <= NONE;
      scan_code <= 4'h0;
    end else begin
      rows_meta <= rows;
      rows_sync <= rows_meta;
      scan_done <= 1'b0;
      if (dwell == DWELL_LAST) begin
        dwell <= '0;
        col   <= col_next;
        cols  <= ~(4'b0001 << col_next);
        if (col == 2'd3) begin
          scan_done <= 1'b1;
          scan_kind <= (tot_cnt == 2'd0) ? NONE : (tot_cnt == 2'd1) ? SINGLE : MULTI;
          scan_code <= tot_code;
          acc_cnt   <= 2'd0;
          acc_code  <= 4'h0;
        end else begin
          acc_cnt   <= tot_cnt;
          acc_code  <= tot_code;
        end
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: per-scan results debounced into key/strobe outputs.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_err
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);

  logic       scan_done;
  scan_kind_t scan_kind;
  logic [3:0] scan_code;

  state_t     state;
  logic [3:0] cand;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rcnt;

  logic is_none;
  logic is_single;

  keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_col_scan (
    .clk       (clk),
    .rst       (rst),
    .rows      (rows),
    .cols      (cols),
    .scan_done (scan_done),
    .scan_kind (scan_kind),
    .scan_code (scan_code)
  );

  always_comb begin
    is_none   = (scan_kind == NONE);
    is_single = (scan_kind == SINGLE);
  end

  // Debounce FSM: acts once per completed scan; strobes last exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= 4'h0;
      cnt       <= '0;
      rcnt      <= '0;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      multi_err <= 1'b0;
      if (scan_done) begin
        multi_err <= (scan_kind == MULTI);
        unique case (state)
          IDLE: begin
            if (is_single) begin
              if (DEBOUNCE == 1) begin
                state     <= HELD;
                key       <= scan_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                state <= PRESS_DB;
                cand  <= scan_code;
                cnt   <= CW'(1);
              end
            end
          end
          PRESS_DB: begin
            if (is_single && scan_code == cand) begin
              if (cnt == DB_LAST) begin
                state     <= HELD;
                key       <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else if (is_single) begin
              cand <= scan_code;
              cnt  <= CW'(1);
            end else begin
              state <= IDLE;
            end
          end
          HELD: begin
            if (!(is_single && scan_code == key)) begin
              if (is_none && DEBOUNCE == 1) begin
                state    <= IDLE;
                key_held <= 1'b0;
              end else begin
                state <= RELEASE_DB;
                rcnt  <= is_none ? CW'(1) : CW'(0);
              end
            end
          end
          RELEASE_DB: begin
            if (is_none) begin
              if (rcnt == DB_LAST) begin
                state    <= IDLE;
                key_held <= 1'b0;
              end else begin
                rcnt <= rcnt + 1'b1;
              end
            end else if (is_single && scan_code == key) begin
              state <= HELD;
            end else begin
              rcnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scan table, corner sequences, random scans vs a scan-level model.
module tb_keypad_scanner;

  localparam int DB = 3;
  localparam logic [15:0] K5 = 16'h0020;
  localparam logic [15:0] KF = 16'h4000;
  localparam logic [15:0] K2 = 16'h0002;
  localparam logic [15:0] KM = 16'h0801;

  typedef struct {
    logic [15:0] keys;
    logic        valid;
    logic [3:0]  key;
    logic        held;
    logic        multi;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic        multi_err;

  logic [15:0] pressed;
  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int mcount = 0;

  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  // Scan-level reference state
  int         m_run;
  int         m_lkind;
  logic [3:0] m_lcode;
  bit         m_held;
  logic [3:0] m_key;
  int         m_acc;
  int         m_multi;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rows      (rows),
    .cols      (cols),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_err (multi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to its column when that column is low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) vcount <= vcount + 1;
    if (multi_err) mcount <= mcount + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] k,
                         input logic h, input logic m);
    chk({tag, ".key_valid"}, 16'(key_valid), 16'(v));
    chk({tag, ".key"},       16'(key),       16'(k));
    chk({tag, ".key_held"},  16'(key_held),  16'(h));
    chk({tag, ".multi_err"}, 16'(multi_err), 16'(m));
  endtask

  // Entry/exit point: #1 after the edge following a column-3 sample.
  task automatic run_scan(input logic [15:0] k);
    pressed = k;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic reset_seq(input logic [15:0] k, input bit check_cols);
    logic [3:0] exp_cols;
    rst = 1'b1;
    pressed = k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk);
      #1;
      if (check_cols) begin
        exp_cols = ~(4'b0001 << ((e / 4) % 4));
        chk($sformatf("rst.cols%0d", e), 16'(cols), 16'(exp_cols));
        chk($sformatf("rst.quiet%0d", e), {9'd0, key, key_valid, key_held, multi_err}, 16'd0);
      end
    end
    @(posedge clk);
    #1;
    chk_out("rst.scan1", 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    m_run = 0; m_lkind = 3; m_lcode = 4'h0;
    m_held = 1'b0; m_key = 4'h0; m_acc = 0; m_multi = 0;
  endtask

  // One full scan: classify the key set, then apply the debounce rules on runs of identical results.
  task automatic model_scan(input logic [15:0] k, output logic ev, output logic em);
    int n;
    int kind;
    logic [3:0] code;
    n = $countones(k);
    code = 4'h0;
    for (int i = 0; i < 16; i++) if (k[i]) code = kmap[i];
    kind = (n == 0) ? 0 : (n == 1) ? 1 : 2;
    if (kind == m_lkind && (kind != 1 || code == m_lcode)) m_run++;
    else m_run = 1;
    m_lkind = kind;
    m_lcode = code;
    ev = 1'b0;
    em = (kind == 2);
    if (em) m_multi++;
    if (!m_held && kind == 1 && m_run == DB) begin
      ev = 1'b1; m_held = 1'b1; m_key = code; m_acc++;
    end else if (m_held && kind == 0 && m_run == DB) begin
      m_held = 1'b0;
    end
  endtask

  function automatic vec_t v(input logic [15:0] k, input logic va, input logic [3:0] ky,
                             input logic h, input logic m);
    vec_t r;
    r.keys = k; r.valid = va; r.key = ky; r.held = h; r.multi = m;
    return r;
  endfunction

  initial begin
    vec_t tab[$];
    logic [15:0] cur;
    logic ev, em;
    int v0, mc0, rr;
    bit got;

    rst = 1'b1;
    pressed = 16'h0;

    tab.push_back(v(K5, 0, 4'h0, 0, 0));
    tab.push_back(v(K5, 0, 4'h0, 0, 0));
    tab.push_back(v(K5, 1, 4'h5, 1, 0));
    tab.push_back(v(K5, 0, 4'h5, 1, 0));
    tab.push_back(v(0,  0, 4'h5, 1, 0));
    tab.push_back(v(0,  0, 4'h5, 1, 0));
    tab.push_back(v(K5, 0, 4'h5, 1, 0));
    tab.push_back(v(0,  0, 4'h5, 1, 0));
    tab.push_back(v(0,  0, 4'h5, 1, 0));
    tab.push_back(v(0,  0, 4'h5, 0, 0));
    tab.push_back(v(KF, 0, 4'h5, 0, 0));
    tab.push_back(v(KF, 0, 4'h5, 0, 0));
    tab.push_back(v(KF, 1, 4'hF, 1, 0));
    tab.push_back(v(KM, 0, 4'hF, 1, 1));
    tab.push_back(v(K5, 0, 4'hF, 1, 0));
    tab.push_back(v(0,  0, 4'hF, 1, 0));
    tab.push_back(v(0,  0, 4'hF, 1, 0));
    tab.push_back(v(0,  0, 4'hF, 0, 0));
    tab.push_back(v(KM, 0, 4'hF, 0, 1));
    tab.push_back(v(KM, 0, 4'hF, 0, 1));
    tab.push_back(v(K5, 0, 4'hF, 0, 0));
    tab.push_back(v(KM, 0, 4'hF, 0, 1));
    tab.push_back(v(K5, 0, 4'hF, 0, 0));
    tab.push_back(v(K5, 0, 4'hF, 0, 0));
    tab.push_back(v(K2, 0, 4'hF, 0, 0));
    tab.push_back(v(K2, 0, 4'hF, 0, 0));
    tab.push_back(v(K2, 1, 4'h2, 1, 0));

    // Reset column walk, then directed scan table
    reset_seq(16'h0, 1'b1);
    for (int i = 0; i < tab.size(); i++) begin
      run_scan(tab[i].keys);
      chk_out($sformatf("tab%0d", i), tab[i].valid, tab[i].key, tab[i].held, tab[i].multi);
    end

    // Async reset while a key is held, then a full fresh debounce of the same key
    reset_seq(K5, 1'b0);
    run_scan(K5);
    run_scan(K5);
    chk_out("pre_rst", 1'b1, 4'h5, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst.key", 16'(key), 16'h0);
    chk("midrst.key_held", 16'(key_held), 16'h0);
    chk("midrst.cols", 16'(cols), 16'h000E);
    chk("midrst.key_valid", 16'(key_valid), 16'h0);
    reset_seq(K5, 1'b0);
    run_scan(K5);
    chk_out("reacc2", 1'b0, 4'h0, 1'b0, 1'b0);
    run_scan(K5);
    chk_out("reacc3", 1'b1, 4'h5, 1'b1, 1'b0);

    // Contact bounce on key F for 40 cycles, then stable
    reset_seq(16'h0, 1'b0);
    v0 = vcount;
    for (int i = 0; i < 8; i++) begin
      pressed = (i % 2 == 0) ? KF : 16'h0;
      repeat (5) @(posedge clk);
      #1;
    end
    chk("bounce.quiet", 16'(vcount - v0), 16'd0);
    pressed = KF;
    got = 1'b0;
    for (int i = 0; i < 160 && !got; i++) begin
      @(negedge clk);
      if (key_valid) got = 1'b1;
    end
    chk("bounce.accept", 16'(got), 16'd1);
    chk("bounce.key", 16'(key), 16'h000F);
    repeat (64) @(posedge clk);
    #1;
    chk("bounce.count", 16'(vcount - v0), 16'd1);
    chk("bounce.held", 16'(key_held), 16'd1);

    // Random key sets per scan against the scan-level model
    reset_seq(16'h0, 1'b0);
    model_reset();
    model_scan(16'h0, ev, em);
    v0 = vcount;
    mc0 = mcount;
    cur = 16'h0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 99) >= 60) begin
        rr = $urandom_range(0, 9);
        if (rr < 4) cur = 16'h0;
        else if (rr < 9) cur = 16'h1 << $urandom_range(0, 15);
        else begin
          rr = $urandom_range(0, 15);
          cur = (16'h1 << rr) | (16'h1 << ((rr + 1 + $urandom_range(0, 14)) % 16));
        end
      end
      run_scan(cur);
      model_scan(cur, ev, em);
      chk_out($sformatf("rnd%0d", i), ev, m_key, m_held, em);
    end
    chk("rnd.valid_count", 16'(vcount - v0), 16'(m_acc));
    chk("rnd.multi_count", 16'(mcount - mc0), 16'(m_multi));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
